// File: rtl/mycpu_pkg.sv
// Shared types and constants for the 16-bit CPU control path.
// Holds opcode, ALU-op, writeback-select and controller-state encodings.
package mycpu_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  typedef enum logic [3:0] {
    OPC_NOP  = 4'h0,
    OPC_ADD  = 4'h1,
    OPC_SUB  = 4'h2,
    OPC_AND  = 4'h3,
    OPC_OR   = 4'h4,
    OPC_XOR  = 4'h5,
    OPC_LDI  = 4'h6,
    OPC_LD   = 4'h7,
    OPC_ST   = 4'h8,
    OPC_JMP  = 4'h9,
    OPC_HALT = 4'hF
  } opcode_t;

  // ALU encoding is opcode-1 for the five arithmetic/logic opcodes.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_IMM  = 2'b10,
    WB_ZERO = 2'b11
  } wb_sel_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } ctrl_state_t;

  function automatic logic is_illegal_opc(input logic [3:0] opc);
    return (opc >= 4'hA) && (opc <= 4'hE);
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_decode.sv
// Combinational opcode decoder for the CPU control unit.
// wb_sel is WB_ZERO for every opcode that does not write the register file.
module cpu_ctrl_decode
  import mycpu_pkg::*;
(
  input  logic [3:0] opcode,
  output alu_op_t    alu_op,
  output wb_sel_t    wb_sel,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_jmp,
  output logic       is_halt,
  output logic       illegal
);

  always_comb begin
    alu_op   = ALU_ADD;
    wb_sel   = WB_ZERO;
    is_mem   = 1'b0;
    is_store = 1'b0;
    is_jmp   = 1'b0;
    is_halt  = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OPC_ADD: begin alu_op = ALU_ADD; wb_sel = WB_ALU; end
      OPC_SUB: begin alu_op = ALU_SUB; wb_sel = WB_ALU; end
      OPC_AND: begin alu_op = ALU_AND; wb_sel = WB_ALU; end
      OPC_OR:  begin alu_op = ALU_OR;  wb_sel = WB_ALU; end
      OPC_XOR: begin alu_op = ALU_XOR; wb_sel = WB_ALU; end
      OPC_LDI: wb_sel = WB_IMM;
      OPC_LD: begin
        is_mem = 1'b1;
        wb_sel = WB_MEM;
      end
      OPC_ST: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      OPC_JMP:  is_jmp  = 1'b1;
      OPC_HALT: is_halt = 1'b1;
      OPC_NOP:  ;
      default:  illegal = is_illegal_opc(opcode);
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM of the 16-bit CPU: fetch/decode/exec/mem/wb/halt.
// Optional memory-wait timeout is compiled in with CPU_CTRL_TIMEOUT_EN.
module cpu_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr_in,
  input  logic             mem_ready_in,
  output logic             mem_req_out,
  output logic             mem_we_out,
  output logic             ir_load_out,
  output logic             pc_inc_out,
  output logic             pc_load_out,
  output logic [2:0]       alu_op_out,
  output logic [1:0]       wb_sel_out,
  output logic             rf_we_out,
  output logic             halt_out,
  output logic             err_out,
  output logic [CNT_W-1:0] instr_cnt_out
);
  import mycpu_pkg::*;

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be in 1..255");
  end

  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_DECODE = ST_DECODE;
  localparam logic [2:0] S_EXEC   = ST_EXEC;
  localparam logic [2:0] S_MEM    = ST_MEM;
  localparam logic [2:0] S_WB     = ST_WB;
  localparam logic [2:0] S_HALT   = ST_HALT;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [3:0]       opcode;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  alu_op_t d_alu_op;
  wb_sel_t d_wb_sel;
  logic    d_is_mem;
  logic    d_is_store;
  logic    d_is_jmp;
  logic    d_is_halt;
  logic    d_illegal;

  logic active;
  logic in_fetch;
  logic in_exec;
  logic in_mem;
  logic in_wb;
  logic in_halt;
  logic mem_phase;
  logic timeout_hit;
  logic retire;
  logic err_set;

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_in[OPC_LSB-1:0];

  cpu_ctrl_decode u_decode (
    .opcode   (opcode),
    .alu_op   (d_alu_op),
    .wb_sel   (d_wb_sel),
    .is_mem   (d_is_mem),
    .is_store (d_is_store),
    .is_jmp   (d_is_jmp),
    .is_halt  (d_is_halt),
    .illegal  (d_illegal)
  );

  // Every strobe is gated by reset so an asserted rst silences the unit at once.
  assign active    = ~rst;
  assign in_fetch  = (state == S_FETCH);
  assign in_exec   = (state == S_EXEC);
  assign in_mem    = (state == S_MEM);
  assign in_wb     = (state == S_WB);
  assign in_halt   = (state == S_HALT);
  assign mem_phase = in_fetch | in_mem;

`ifdef CPU_CTRL_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Counter restarts whenever the memory phase is left, so each FETCH/MEM entry begins at 0.
  always_ff @(posedge clk) begin
    if (rst || !mem_phase || mem_ready_in) begin
      wait_cnt <= 8'd0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign timeout_hit = mem_phase && !mem_ready_in && (wait_cnt == 8'(MEM_TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (mem_ready_in)     state_nxt = S_DECODE;
        else if (timeout_hit) state_nxt = S_HALT;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (d_is_halt)              state_nxt = S_HALT;
        else if (d_is_mem)          state_nxt = S_MEM;
        else if (d_wb_sel != WB_ZERO) state_nxt = S_WB;
        else                        state_nxt = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready_in)     state_nxt = d_is_store ? S_FETCH : S_WB;
        else if (timeout_hit) state_nxt = S_HALT;
      end
      S_WB:    state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its last state.
  assign retire  = in_wb
                 | (in_exec && !d_is_mem && (d_wb_sel == WB_ZERO))
                 | (in_mem && mem_ready_in && d_is_store);
  assign err_set = (in_exec && d_illegal) | timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      opcode <= 4'h0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state <= state_nxt;
      if (ir_load_out) opcode <= instr_in[OPC_MSB:OPC_LSB];
      if (err_set)     err_q  <= 1'b1;
      if (retire)      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign mem_req_out   = active && mem_phase && !timeout_hit;
  assign mem_we_out    = active && in_mem && d_is_store;
  assign ir_load_out   = active && in_fetch && mem_ready_in;
  assign pc_inc_out    = active && in_fetch && mem_ready_in;
  assign pc_load_out   = active && in_exec && d_is_jmp;
  assign alu_op_out    = (active && (in_exec || in_wb)) ? d_alu_op : ALU_ADD;
  assign wb_sel_out    = (active && in_wb) ? d_wb_sel : WB_ALU;
  assign rf_we_out     = active && in_wb;
  assign halt_out      = active && in_halt;
  assign err_out       = active && err_q;
  assign instr_cnt_out = active ? cnt_q : '0;

endmodule
